// File: rtl/acc_pkg.sv
// Shared types for the chunked accumulator: request modes and FSM states.
// Imported by chunk_adder and seq_chunk_accumulator.
package acc_pkg;

  typedef enum logic [1:0] {
    M_ADD = 2'b00,
    M_SUB = 2'b01,
    M_ACC = 2'b10,
    M_CLR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational adder slice.
// Ports: x, y, cin in; sum, cout, c_msb (carry into the top bit) out.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};

  // The carry into the top bit is recovered from that bit's sum.
  assign c_msb = sum[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/seq_chunk_accumulator.sv
// Multi-cycle add/sub/accumulate unit, CHUNK bits per clock, LSB first.
// Ports: i_clk, i_rst, valid/ready request (i_mode, i_va, i_vb, i_c0), result o_v/flags/o_acc.
module seq_chunk_accumulator
  import acc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_va,
  input  logic [WIDTH-1:0] i_vb,
  input  logic             i_c0,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_v,
  output logic             o_c,
  output logic             o_ovf,
  output logic             o_zero,
  output logic [WIDTH-1:0] o_acc
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e state, state_n;
  mode_e  mode, req;

  logic [WIDTH-1:0] x, y, res, full;
  logic [CHUNK-1:0] xs, ys, sum;
  logic [CW-1:0]    cnt;
  logic             carry, cout, c_msb;
  logic             accept, last;

  assign req     = mode_e'(i_mode);
  assign o_ready = (state != S_RUN);
  assign o_valid = (state == S_DONE);
  assign accept  = i_valid && o_ready;
  assign last    = (state == S_RUN) && (cnt == LAST);

  assign xs = x[cnt*CHUNK +: CHUNK];
  assign ys = y[cnt*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .x     (xs),
    .y     (ys),
    .cin   (carry),
    .sum   (sum),
    .cout  (cout),
    .c_msb (c_msb)
  );

  // Partial result with the current chunk merged in.
  always_comb begin
    full = res;
    full[cnt*CHUNK +: CHUNK] = sum;
  end

  always_comb begin
    state_n = state;
    if (state == S_RUN) begin
      if (cnt == LAST) state_n = S_DONE;
    end else if (accept) begin
      state_n = (req == M_CLR) ? S_DONE : S_RUN;
    end else begin
      state_n = S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode   <= M_ADD;
      x      <= '0;
      y      <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      o_v    <= '0;
      o_c    <= 1'b0;
      o_ovf  <= 1'b0;
      o_zero <= 1'b1;
      o_acc  <= '0;
    end else if (accept) begin
      mode <= req;
      cnt  <= '0;
      unique case (req)
        M_ADD: begin
          x     <= i_va;
          y     <= i_vb;
          carry <= i_c0;
        end
        M_SUB: begin
          x     <= i_va;
          y     <= ~i_vb;
          carry <= 1'b1;
        end
        M_ACC: begin
          x     <= o_acc;
          y     <= i_va;
          carry <= i_c0;
        end
        M_CLR: begin
          o_v    <= '0;
          o_acc  <= '0;
          o_c    <= 1'b0;
          o_ovf  <= 1'b0;
          o_zero <= 1'b1;
        end
      endcase
    end else if (state == S_RUN) begin
      res   <= full;
      carry <= cout;
      cnt   <= cnt + CW'(1);
      if (last) begin
        o_v    <= full;
        o_c    <= cout;
        o_ovf  <= cout ^ c_msb;
        o_zero <= (full == '0);
        if (mode == M_ACC) o_acc <= full;
      end
    end
  end

endmodule

// File: doc/seq_chunk_accumulator.md
# seq_chunk_accumulator

Parametrised, multi-cycle successor to the 32-bit combinational adder. It adds, subtracts or accumulates two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, with a registered carry between chunks. It also keeps an internal accumulator register and reports carry, signed overflow and zero flags. It sits in the datapath as the shared arithmetic unit behind a valid/ready request interface, trading latency for a short carry chain.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK
- CHUNK, 8, bits added per cycle; 1..WIDTH; NCHUNK = WIDTH/CHUNK
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  request valid
- o_ready  out  1  unit can accept a request: high in IDLE and DONE, low in RUN
- i_mode  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
- i_va  in  WIDTH  operand A
- i_vb  in  WIDTH  operand B (ignored by ACC and CLR)
- i_c0  in  1  carry-in (ADD, ACC only)
- o_valid  out  1  one-cycle pulse: result valid
- o_v  out  WIDTH  result, held until the next completion
- o_c  out  1  carry-out of bit WIDTH-1 (SUB: 1 = no borrow)
- o_ovf  out  1  signed overflow
- o_zero  out  1  o_v == 0
- o_acc  out  WIDTH  accumulator register

## Operation
- Accept occurs when i_valid && o_ready at a rising edge. i_mode, i_va, i_vb and i_c0 are captured there; input changes afterwards are ignored until the next accept.
- Operand X per mode:
  - ADD: X=A, Y=B, cin=i_c0.
  - SUB: X=A, Y=~B, cin=1 (i_c0 ignored).
  - ACC: X=o_acc, Y=A, cin=i_c0.
  - CLR: no add.
- FSM IDLE→RUN on accept (ADD/SUB/ACC).
- RUN: chunk index k = 0..NCHUNK-1, one chunk per edge. Result bits [k*CHUNK +: CHUNK] are written and the chunk carry is registered as cin of chunk k+1. After the edge that computes chunk NCHUNK-1, go to DONE.
- CLR: IDLE/DONE→DONE in one edge. Sets o_v=0, o_acc=0, o_c=0, o_ovf=0, o_zero=1.
- DONE lasts exactly one cycle with o_valid=1, o_ready=1. An accept in DONE goes straight to RUN (or DONE for CLR); otherwise go to IDLE.
- ACC completion also writes o_acc := o_v. ADD and SUB leave o_acc unchanged.
- o_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. Arithmetic is modulo 2^WIDTH; there is no saturation.
- o_v, o_c, o_ovf and o_zero update only on completion. Partial chunks are held internally and are not visible until o_valid.

## Timing
- Reset: state IDLE; o_ready=1, o_valid=0, o_v=0, o_c=0, o_ovf=0, o_zero=1, o_acc=0.
- Latency for ADD/SUB/ACC: accept at edge E0, o_valid high in the cycle after edge E(NCHUNK). That is NCHUNK cycles; for CHUNK=WIDTH it is 1.
- Latency for CLR: 1 cycle.
- Throughput: one op per NCHUNK cycles with back-to-back accepts in DONE.
- Reset mid-RUN aborts the operation: no o_valid, all outputs return to reset values, and partial results are discarded.
- i_valid during RUN is not accepted; the requester holds it until o_ready.

## Structure
- Shared package `acc_pkg`:
  - mode enum (ADD/SUB/ACC/CLR)
  - FSM state enum (IDLE/RUN/DONE)
- Sub-module `chunk_adder` (CHUNK-bit combinational adder):
  - inputs: x, y, cin
  - outputs: sum, cout, c_msb (carry into MSB, used for overflow on the last chunk)
- Top level holds the FSM, chunk counter ($clog2(NCHUNK) bits, min 1), captured operands, result shift/slice register and accumulator.

## Test plan
- WIDTH=32, CHUNK=8, ADD A=0x00000001, B=0x00000001, c0=1 → o_v=0x00000003, o_c=0, o_ovf=0, o_zero=0; o_valid exactly 4 cycles after accept edge, one cycle wide.
- ADD 0xFFFFFFFF+0x00000001, c0=0 → o_v=0, o_c=1, o_zero=1, o_ovf=0 (carry ripples across all 4 chunks). ADD 0x7FFFFFFF+1 → 0x80000000, o_ovf=1, o_c=0.
- SUB 0x00000005−0x00000006 → 0xFFFFFFFF, o_c=0, o_ovf=0; SUB 6−5 → 0x00000001, o_c=1. SUB 0x80000000−1 → 0x7FFFFFFF, o_ovf=1.
- CLR, then ACC A=5, c0=1 three times back-to-back (accept in DONE) → o_acc 0x6, 0xC, 0x12; o_valid pulses spaced 4 cycles apart.
- i_rst asserted for 1 cycle at chunk 2 of an ADD → no o_valid; next cycle o_ready=1, o_acc=0, o_zero=1. i_va toggled during RUN does not change the result.
- Rebuild with CHUNK=32 and CHUNK=1 → same results as above; latency 1 and 32 cycles respectively.
